// File: rtl/mem_seq_pkg.sv
// Shared constants and state encoding for the scratch-memory command sequencer.
package mem_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 5;
  localparam logic [DATA_W-1:0] PROBE_FILL = 8'h00;

  typedef enum logic [3:0] {
    INIT_PROBE,
    INIT_RESTORE,
    INIT_SETTLE,
    IDLE,
    RD_PROBE,
    RD_RESTORE,
    RD_SETTLE,
    WR_PROBE,
    WR_SETTLE,
    RESP
  } seq_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < int'(DEPTH));
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Host-side command/response handshake bundle for mem_sequencer.
interface mem_sequencer_if;
  import mem_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_sequencer.sv
// Turns host read/write commands into clobber-free access sequences on a
// read-before-write scratch memory, parking on the last visited entry.
module mem_sequencer
  import mem_seq_pkg::*;
(
  input  logic              seq_iclk,
  input  logic              seq_irst_n,
  mem_sequencer_if.slave    bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_idata,
  input  logic [DATA_W-1:0] mem_odata
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] park_q, park_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_ready;
  logic              init_visit;
  logic [ADDR_W-1:0] visit_addr;

  always_ff @(posedge seq_iclk or negedge seq_irst_n) begin
    if (!seq_irst_n) begin
      state_q     <= INIT_PROBE;
      park_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      park_q      <= park_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // INIT and read-miss visits share one probe/restore/settle datapath.
  assign init_visit = (state_q == INIT_PROBE) || (state_q == INIT_RESTORE) ||
                      (state_q == INIT_SETTLE);
  assign visit_addr = init_visit ? '0 : addr_q;

  always_comb begin
    state_d     = state_q;
    park_d      = park_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready   = 1'b0;
    // Parked: rewrite the entry at park with its own registered content.
    mem_addr    = park_q;
    mem_idata   = mem_odata;

    unique case (state_q)
      INIT_PROBE, RD_PROBE: begin
        mem_addr  = visit_addr;
        mem_idata = PROBE_FILL;
        state_d   = init_visit ? INIT_RESTORE : RD_RESTORE;
      end
      INIT_RESTORE, RD_RESTORE: begin
        mem_addr  = visit_addr;
        mem_idata = mem_odata;
        rdata_d   = mem_odata;
        state_d   = init_visit ? INIT_SETTLE : RD_SETTLE;
      end
      INIT_SETTLE, RD_SETTLE: begin
        mem_addr  = visit_addr;
        mem_idata = rdata_q;
        park_d    = visit_addr;
        if (init_visit) begin
          state_d = IDLE;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_q;
          rsp_err_d   = 1'b0;
        end
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          if (!addr_in_range(bus.cmd_addr)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (bus.cmd_we) begin
            state_d = WR_PROBE;
          end else if (bus.cmd_addr == park_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_odata;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = RD_PROBE;
          end
        end
      end
      WR_PROBE: begin
        mem_addr  = addr_q;
        mem_idata = wdata_q;
        state_d   = WR_SETTLE;
      end
      WR_SETTLE: begin
        mem_addr    = addr_q;
        mem_idata   = wdata_q;
        park_d      = addr_q;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = INIT_PROBE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer driving a read-before-write 5x8 memory model.
module tb_mem_sequencer;
  import mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic preload = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_sequencer_if bus();
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_idata;
  logic [DATA_W-1:0] mem_odata;
  logic [7:0] tb_mem [5];

  mem_sequencer dut (
    .seq_iclk  (clk),
    .seq_irst_n(rst_n),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_idata (mem_idata),
    .mem_odata (mem_odata)
  );

  always @(posedge clk) begin
    if (preload) begin
      tb_mem[0] <= 8'h00; tb_mem[1] <= 8'h01; tb_mem[2] <= 8'h02;
      tb_mem[3] <= 8'h03; tb_mem[4] <= 8'h04;
      mem_odata <= 8'h00;
    end else if (int'(mem_addr) < 5) begin
      mem_odata <= tb_mem[int'(mem_addr)];
      tb_mem[int'(mem_addr)] <= mem_idata;
    end
  end

  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] d,
                       output int lat);
    int w = 0;
    while (!bus.cmd_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!bus.cmd_ready) begin lat = -1; return; end
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_we = ~we; bus.cmd_addr = ~a; bus.cmd_wdata = ~d;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=00", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", bus.rsp_err); end
    total++; if (mem_addr !== 3'd0) begin bad++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
    total++; if (mem_idata !== 8'h00) begin bad++; $display("FAIL rst_mem_idata got=%h exp=00", mem_idata); end
    preload = 1'b0;
    rst_n = 1'b1;
    cyc = 1;
    while (!bus.cmd_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 4) begin bad++; $display("FAIL init_ready_cycle got=%0d exp=4", cyc); end
    for (int i = 0; i < 5; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL init_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_read_hit();
    int lat;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    issue(1'b0, 3'd0, 8'h00, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL hit0_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL hit0_rdata got=%h exp=00", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL hit0_err got=%b exp=0", bus.rsp_err); end
    ack();
    for (int i = 0; i < 5; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL hit0_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_read_miss();
    int lat;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    issue(1'b0, 3'd3, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL miss3_lat got=%0d exp=4", lat); end
    total++; if (bus.rsp_rdata !== 8'h03) begin bad++; $display("FAIL miss3_rdata got=%h exp=03", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL miss3_err got=%b exp=0", bus.rsp_err); end
    ack();
    for (int i = 0; i < 5; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL miss3_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
    issue(1'b0, 3'd3, 8'h00, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL hit3_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_rdata !== 8'h03) begin bad++; $display("FAIL hit3_rdata got=%h exp=03", bus.rsp_rdata); end
    ack();
  endtask

  task automatic test_write();
    int lat;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h04};
    issue(1'b1, 3'd2, 8'hA5, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr2_lat got=%0d exp=3", lat); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL wr2_rdata got=%h exp=00", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL wr2_err got=%b exp=0", bus.rsp_err); end
    ack();
    issue(1'b0, 3'd2, 8'h00, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL rd2_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_rdata !== 8'hA5) begin bad++; $display("FAIL rd2_rdata got=%h exp=a5", bus.rsp_rdata); end
    ack();
    issue(1'b0, 3'd3, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd3_lat got=%0d exp=4", lat); end
    total++; if (bus.rsp_rdata !== 8'h03) begin bad++; $display("FAIL rd3_rdata got=%h exp=03", bus.rsp_rdata); end
    ack();
    issue(1'b0, 3'd1, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd1_lat got=%0d exp=4", lat); end
    total++; if (bus.rsp_rdata !== 8'h01) begin bad++; $display("FAIL rd1_rdata got=%h exp=01", bus.rsp_rdata); end
    ack();
    for (int i = 0; i < 5; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL wr_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_error();
    int lat;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h04};
    issue(1'b0, 3'd6, 8'h00, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL err_rd6_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL err_rd6_err got=%b exp=1", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL err_rd6_rdata got=%h exp=00", bus.rsp_rdata); end
    ack();
    issue(1'b1, 3'd7, 8'hFF, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL err_wr7_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL err_wr7_err got=%b exp=1", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL err_wr7_rdata got=%h exp=00", bus.rsp_rdata); end
    ack();
    for (int i = 0; i < 5; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL err_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
    // park was left at 1: a read of 1 must still hit
    issue(1'b0, 3'd1, 8'h00, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL err_park_lat got=%0d exp=1", lat); end
    total++; if (bus.rsp_rdata !== 8'h01) begin bad++; $display("FAIL err_park_rdata got=%h exp=01", bus.rsp_rdata); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] exp_mem [5] = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h04};
    issue(1'b0, 3'd4, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_lat got=%0d exp=4", lat); end
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, bus.rsp_valid); end
      total++; if (bus.rsp_rdata !== 8'h04) begin bad++; $display("FAIL bp_rdata[%0d] got=%h exp=04", c, bus.rsp_rdata); end
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready[%0d] got=%b exp=0", c, bus.cmd_ready); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL bp_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
      end
    end
    ack();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int cyc;
    logic [7:0] e4;
    logic [7:0] exp_mem [4] = '{8'h00, 8'h01, 8'hA5, 8'h03};
    issue(1'b0, 3'd0, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_rd0_lat got=%0d exp=4", lat); end
    ack();
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 3'd4; bus.cmd_wdata = 8'h00;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_addr !== 3'd4) begin bad++; $display("FAIL mid_restore_addr got=%0d exp=4", mem_addr); end
    rst_n = 1'b0;
    #2;
    total++; if (mem_addr !== 3'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d exp=0", mem_addr); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus.rsp_valid); end
    rst_n = 1'b1;
    cyc = 1;
    while (!bus.cmd_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 4) begin bad++; $display("FAIL mid_ready_cycle got=%0d exp=4", cyc); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tb_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL mid_mem[%0d] got=%h exp=%h", i, tb_mem[i], exp_mem[i]); end
    end
    e4 = tb_mem[4];
    total++; if (e4 !== 8'h00 && e4 !== 8'h04) begin bad++; $display("FAIL mid_mem4 got=%h exp=00_or_04", e4); end
    issue(1'b0, 3'd4, 8'h00, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_rd4_lat got=%0d exp=4", lat); end
    total++; if (bus.rsp_rdata !== e4) begin bad++; $display("FAIL mid_rd4_rdata got=%h exp=%h", bus.rsp_rdata, e4); end
    ack();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
